// File: rtl/pingpong_buf_ctrl.sv
// ---------------------------------------------------------------------------
// PingpongBufCtrl (module pingpong_buf_ctrl)
//
// Purpose:
//   Controls two dual-port RAM banks as a ping-pong frame buffer. A byte
//   stream is written frame by frame into one bank while the other, already
//   complete bank is drained to an output stream. Port A of each bank is the
//   write side; port B is the read side with one cycle of read latency.
//
// Optional feature macro: PINGPONG_BUF_CTRL_FRAME_CNT_EN
//   When defined, adds output frame_cnt[15:0], counting completed output
//   frames (wrapping at 16 bits).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_len                bytes per frame, sampled at each frame's first byte
//   in_valid/in_ready        write-stream handshake
//   in_data                  write-stream byte
//   bankN_ena/wea/addra/dina port-A write controls for bank N (N=0,1)
//   bankN_enb/addrb          port-B read controls for bank N
//   bankN_doutb              port-B read data (1-cycle latency)
//   out_ready                downstream credit for issuing a read this cycle
//   out_valid/out_data/out_last  output stream (no backpressure after issue)
//   bank_full                per-bank frame-complete flags
//   frame_cnt                (optional) completed output frame count
// ---------------------------------------------------------------------------
module pingpong_buf_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bank0_ena,
  output logic              bank0_wea,
  output logic [ADDR_W-1:0] bank0_addra,
  output logic [DATA_W-1:0] bank0_dina,
  output logic              bank0_enb,
  output logic [ADDR_W-1:0] bank0_addrb,
  input  logic [DATA_W-1:0] bank0_doutb,
  output logic              bank1_ena,
  output logic              bank1_wea,
  output logic [ADDR_W-1:0] bank1_addra,
  output logic [DATA_W-1:0] bank1_dina,
  output logic              bank1_enb,
  output logic [ADDR_W-1:0] bank1_addrb,
  input  logic [DATA_W-1:0] bank1_doutb,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        bank_full
`ifdef PINGPONG_BUF_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  typedef enum logic {R_IDLE, R_READ} rd_state_t;

  rd_state_t         r_state;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_len [2];
  logic [1:0]        r_full;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_out_bank;

  logic [ADDR_W-1:0] w_eff_len;
  logic [ADDR_W-1:0] w_rd_len;
  logic              w_in_ready;
  logic              w_wr_fire;
  logic              w_wr_last;
  logic              w_rd_fire;
  logic              w_rd_last;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  // At the first byte of a frame the live frame_len governs; afterwards the
  // length latched for the bank being filled does, so mid-frame changes of
  // frame_len are ignored. in_ready is forced low during reset so that every
  // output reads 0 while rst is held.
  assign w_eff_len  = (r_wr_addr == '0) ? frame_len : r_len[r_wr_bank];
  assign w_in_ready = !rst && !r_full[r_wr_bank] && (w_eff_len != '0);
  assign w_wr_fire  = in_valid && w_in_ready;
  assign w_wr_last  = w_wr_fire && (r_wr_addr == w_eff_len - ADDR_W'(1));

  assign w_rd_len   = r_len[r_rd_bank];
  assign w_rd_fire  = (r_state == R_READ) && out_ready;
  assign w_rd_last  = w_rd_fire && (r_rd_addr == w_rd_len - ADDR_W'(1));

  // Writer and reader always work on different banks, so a set and a clear
  // in the same cycle touch different flags and both must survive.
  assign w_set = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  assign in_ready    = w_in_ready;

  assign bank0_ena   = w_wr_fire && !r_wr_bank;
  assign bank0_wea   = w_wr_fire && !r_wr_bank;
  assign bank0_addra = r_wr_addr;
  assign bank0_dina  = (w_wr_fire && !r_wr_bank) ? in_data : '0;
  assign bank1_ena   = w_wr_fire && r_wr_bank;
  assign bank1_wea   = w_wr_fire && r_wr_bank;
  assign bank1_addra = r_wr_addr;
  assign bank1_dina  = (w_wr_fire && r_wr_bank) ? in_data : '0;

  assign bank0_enb   = w_rd_fire && !r_rd_bank;
  assign bank0_addrb = r_rd_addr;
  assign bank1_enb   = w_rd_fire && r_rd_bank;
  assign bank1_addrb = r_rd_addr;

  // Read data arrives one cycle after issue, so the bank mux uses the bank
  // registered at issue time, not the current rd_bank.
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_valid ? (r_out_bank ? bank1_doutb : bank0_doutb) : '0;
  assign bank_full = r_full;

  // Writer counters, length latches, full flags and the reader FSM with its
  // registered output-stream qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_full      <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_bank  <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;

      if (w_wr_fire) begin
        if (r_wr_addr == '0) begin
          r_len[r_wr_bank] <= frame_len;
        end
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_wr_addr <= '0;
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
      end

      r_out_valid <= w_rd_fire;
      r_out_last  <= w_rd_last;
      if (w_rd_fire) begin
        r_out_bank <= r_rd_bank;
      end

      case (r_state)
        R_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state <= R_READ;
          end
        end
        R_READ: begin
          if (w_rd_fire) begin
            if (w_rd_last) begin
              r_rd_bank <= ~r_rd_bank;
              r_rd_addr <= '0;
              r_state   <= R_IDLE;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef PINGPONG_BUF_CTRL_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts frames as their last byte leaves the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
    end else if (r_out_valid && r_out_last) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
